seg_scan_driver: RTL and testbench
==================================

# seg_scan_driver

Time-multiplexed scan driver for the 4-digit seven-segment display: owns the digit-select sequencing that feeds the board's anode lines, and decodes each selected hex nibble to segments. Accepts a 16-bit value via a load strobe and double-buffers it so updates land only on frame boundaries. Sits between the datapath/top-level and the display pins, replacing free-running select logic with a registered scan with anti-ghost blanking.

## Interface
- DIGIT_CYCLES, 100000: clocks per digit slot, minimum 4.
- BLANK_CYCLES, 1000: clocks at the start of each slot with all anodes off; must be less than DIGIT_CYCLES.
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- load  input  1  single-cycle strobe; captures `value` and `dp_in` into the pending buffer.
- value  input  16  four hex digits; digit 0 = value[3:0] (rightmost), digit 3 = value[15:12].
- dp_in  input  4  per-digit decimal point request, active-high, bit i = digit i.
- an  output  4  anode enables, active-low, bit i = digit i.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  output  1  decimal point, active-low.
- frame_done  output  1  one-cycle pulse at the end of digit 3's slot.
- updated  output  1  one-cycle pulse when the pending buffer is copied to the display buffer.

## Operation
- Slot counter `cnt` counts 0..DIGIT_CYCLES-1 and wraps. At wrap, digit index `idx` advances 0→1→2→3→0.
- FSM with two states per slot. BLANK: cnt < BLANK_CYCLES, an = 4'b1111, seg = 7'h7F, dp = 1. SHOW: remaining cycles, an = ~(4'b0001 << idx), seg = decode(display nibble idx), dp = ~display_dp[idx].
- Hex decode covers 0–F: 0→7'h40, 1→7'h79, 8→7'h00, A→7'h08, F→7'h0E.
- load writes pending buffer and sets pending_valid. A later load before the boundary overwrites it. Last load wins.
- Frame boundary is cnt wrap with idx = 3. frame_done pulses. If pending_valid, the display buffer takes the pending contents, pending_valid clears and updated pulses in the same cycle.
- If load and the boundary occur in the same cycle, the boundary copies the previously pending contents. The new load stays pending for the next frame. If nothing was pending, no update occurs and updated stays 0.
- Reset, asynchronous and taking effect at any point mid-scan: cnt = 0, idx = 0, FSM = BLANK, both buffers = 0, pending_valid = 0, an = 4'hF, seg = 7'h7F, dp = 1, frame_done = 0, updated = 0.

## Timing
- All outputs are registered. an, seg and dp reflect the counter state of the previous cycle, giving one cycle of latency.
- Slot = DIGIT_CYCLES clocks. Frame = 4·DIGIT_CYCLES clocks. Refresh rate = f_clk / (4·DIGIT_CYCLES).
- After reset is released, the first SHOW for digit 0 appears at output cycle BLANK_CYCLES+1. The first frame_done occurs 4·DIGIT_CYCLES cycles after reset is released.
- Load-to-display latency is at most one frame plus one slot of blanking. It is never mid-frame, so no digit tears.

## Configuration
- SEG_LEADING_ZERO_BLANK_EN defined: during SHOW, digit i is forced blank (seg = 7'h7F, anode still asserted) when every nibble from digit 3 down to digit i is 0 and i ≠ 0. Digit 0 always shows. dp is unaffected.
- Macro undefined: all four digits always show their nibble, including leading zeros.

## Structure
- The package seg_pkg holds three items: the FSM state typedef (BLANK, SHOW), the segment constants SEG_OFF = 7'h7F and AN_OFF = 4'hF, and the 16-entry hex-to-segment constant table.
- Sub-module hex_to_seg is purely combinational. Its input is a 4-bit nibble and its output is 7-bit seg. It is instantiated once on the selected nibble.

## Test plan
- Reset mid-scan with DIGIT_CYCLES=8, BLANK_CYCLES=2 → an=4'hF, seg=7'h7F, dp=1 immediately. After release, idx=0 and BLANK then SHOW follow the timing above.
- load value=16'h12AF, dp_in=4'b0100, then run 2 frames → digit 0 shows seg=7'h0E (F), digit 1 shows 7'h08 (A), digit 2 shows 7'h24 with dp=0, digit 3 shows 7'h79. The sequence for an is E,D,B,7.
- Each slot → exactly 2 cycles of an=4'hF, then 6 cycles with one anode low. frame_done occurs every 32 cycles.
- load 16'h1111, then load 16'h2222 before the boundary → a single updated pulse, and only 2s are displayed.
- load 16'h3333 in the exact boundary cycle while 16'h1111 is pending → 1s are shown this frame and 3s next frame, with updated pulsing at both boundaries.
- With SEG_LEADING_ZERO_BLANK_EN, load 16'h0050 → digits 3 and 2 show seg=7'h7F with anodes active, digit 1 shows 5 (7'h12), and digit 0 shows 0 (7'h40).

Source files
------------

// File: rtl/seg_pkg.sv
// seg_pkg: shared types and constants for the seven-segment scan driver.
// Holds the slot FSM state type, the all-off segment/anode patterns and the
// active-low hex-to-segment table ({g,f,e,d,c,b,a}, index = nibble value).
package seg_pkg;
  typedef enum logic {BLANK = 1'b0, SHOW = 1'b1} state_t;
  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] AN_OFF = 4'hF;
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };
endpackage

// File: rtl/seg_scan_driver_hex_to_seg.sv
// hex_to_seg: combinational hex nibble to active-low seven-segment decode.
// Ports: nibble (4-bit hex digit in), seg (7-bit {g,f,e,d,c,b,a}, active-low out).
module hex_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);
  assign seg = HEX_SEG[nibble];
endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: registered 4-digit seven-segment scan with anti-ghost blanking.
// Ports: clk, reset (async active-high), load/value/dp_in (pending-buffer write),
//   an (active-low anodes), seg (active-low {g,f,e,d,c,b,a}), dp (active-low),
//   frame_done (pulse at end of digit 3 slot), updated (pulse on buffer swap).
// Optional: define SEG_LEADING_ZERO_BLANK_EN to blank leading-zero digits 3..1.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int DIGIT_CYCLES = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done,
  output logic        updated
);
  localparam int CW = $clog2(DIGIT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  state_t        state_q, state_d;
  // Buffers hold {dp[3:0], value[15:0]}.
  logic [19:0]   disp_q, disp_d, pend_q, pend_d;
  logic          pv_q, pv_d;
  logic          wrap, boundary, show, lz, dp_sel;
  logic [3:0]    nib, an_d;
  logic [6:0]    hex, seg_d;
  logic          dp_d;

  hex_to_seg u_hex (.nibble(nib), .seg(hex));

  always_comb begin
    wrap     = cnt_q == CNT_LAST;
    boundary = wrap && idx_q == 2'd3;
    cnt_d    = wrap ? '0 : cnt_q + 1'b1;
    idx_d    = wrap ? idx_q + 2'd1 : idx_q;
    // state_q tracks cnt_q, so outputs registered from it lag the counter by one.
    state_d  = cnt_d < CNT_BLANK ? BLANK : SHOW;
    pend_d   = load ? {dp_in, value} : pend_q;
    // A load coinciding with the boundary stays pending for the next frame.
    pv_d     = load | (pv_q & ~boundary);
    disp_d   = (boundary && pv_q) ? pend_q : disp_q;
    nib      = disp_q[{idx_q, 2'b00} +: 4];
    dp_sel   = disp_q[5'd16 + {3'd0, idx_q}];
`ifdef SEG_LEADING_ZERO_BLANK_EN
    lz = (idx_q == 2'd3 && disp_q[15:12] == 4'd0) ||
         (idx_q == 2'd2 && disp_q[15:8] == 8'd0) ||
         (idx_q == 2'd1 && disp_q[15:4] == 12'd0);
`else
    lz = 1'b0;
`endif
    show  = state_q == SHOW;
    an_d  = show ? ~(4'b0001 << idx_q) : AN_OFF;
    seg_d = (show && !lz) ? hex : SEG_OFF;
    dp_d  = show ? ~dp_sel : 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      state_q    <= BLANK;
      disp_q     <= '0;
      pend_q     <= '0;
      pv_q       <= 1'b0;
      an         <= AN_OFF;
      seg        <= SEG_OFF;
      dp         <= 1'b1;
      frame_done <= 1'b0;
      updated    <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      state_q    <= state_d;
      disp_q     <= disp_d;
      pend_q     <= pend_d;
      pv_q       <= pv_d;
      an         <= an_d;
      seg        <= seg_d;
      dp         <= dp_d;
      frame_done <= boundary;
      updated    <= boundary && pv_q;
    end
  end
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: scoreboard bench for seg_scan_driver (DIGIT_CYCLES=8, BLANK_CYCLES=2).
module tb_seg_scan_driver;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp, frame_done, updated;

  seg_scan_driver #(.DIGIT_CYCLES(8), .BLANK_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .load(load), .value(value), .dp_in(dp_in),
    .an(an), .seg(seg), .dp(dp), .frame_done(frame_done), .updated(updated)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [3:0] an; logic [6:0] seg; logic dp;} exp_t;
  exp_t exp_q[$];
  int   upd_q[$];
  exp_t cur;
  int   checks = 0, errors = 0, cyc = 0;
  bit   mon_en = 1'b0;
  logic [3:0] prev_an = 4'hF;
  int   blank_len = 0, show_len = 0, next_fd = 32, fd_cnt = 0;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
      4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
      4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
      4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_frame(input logic [15:0] v, input logic [3:0] d);
    for (int i = 0; i < 4; i++) begin
      exp_t e;
      logic lz;
`ifdef SEG_LEADING_ZERO_BLANK_EN
      lz = (i != 0) && ((v >> (4 * i)) == 16'd0);
`else
      lz = 1'b0;
`endif
      e.an  = ~(4'b0001 << i);
      e.seg = lz ? 7'h7F : hex7(v[4*i +: 4]);
      e.dp  = ~d[i];
      exp_q.push_back(e);
    end
  endtask

  // Drive load so that it is sampled at rising edge number e after release.
  task automatic load_at(input int e, input logic [15:0] v, input logic [3:0] d);
    while (cyc != e - 1) @(negedge clk);
    load = 1'b1; value = v; dp_in = d;
    @(negedge clk);
    load = 1'b0;
  endtask

  always @(posedge clk) if (mon_en) cyc <= cyc + 1;

  always @(negedge clk) if (mon_en) begin
    if (an != 4'hF) begin
      if (prev_an == 4'hF) begin
        chk("blank_len", blank_len, 2);
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL show_underflow: got an=%h expected no digit (cyc %0d)", an, cyc);
          cur = '{an: an, seg: seg, dp: dp};
        end else cur = exp_q.pop_front();
        show_len = 1;
      end else show_len++;
      chk("an", an, cur.an);
      chk("seg", seg, cur.seg);
      chk("dp", dp, cur.dp);
    end else begin
      if (prev_an != 4'hF) begin
        chk("show_len", show_len, 6);
        blank_len = 1;
      end else blank_len++;
      chk("blank_seg", seg, 7'h7F);
      chk("blank_dp", dp, 1);
    end
    prev_an = an;
    if (frame_done) begin
      fd_cnt++;
      chk("frame_done_cyc", cyc, next_fd);
      next_fd += 32;
    end
    if (updated) begin
      if (upd_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL updated_unexpected: got pulse at cyc %0d expected none", cyc);
      end else chk("updated_cyc", cyc, upd_q.pop_front());
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(negedge clk);
    load = 1'b1; value = 16'hFFFF; dp_in = 4'hF;
    @(negedge clk);
    load = 1'b0;
    repeat (44) @(negedge clk);
    @(posedge clk);
    #3;
    chk("pre_reset_an", an, 4'hD);
    chk("pre_reset_seg", seg, 7'h0E);
    chk("pre_reset_dp", dp, 0);
    reset = 1'b1;
    #1;
    chk("rst_an", an, 4'hF);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_dp", dp, 1);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_updated", updated, 0);
    repeat (2) @(negedge clk);
    #1;
    reset = 1'b0;
    mon_en = 1'b1;
    push_frame(16'h0000, 4'b0000);
    load_at(5, 16'h12AF, 4'b0100);
    push_frame(16'h12AF, 4'b0100);
    push_frame(16'h12AF, 4'b0100);
    upd_q.push_back(32);
    load_at(70, 16'h1111, 4'b0000);
    load_at(80, 16'h2222, 4'b0000);
    push_frame(16'h2222, 4'b0000);
    upd_q.push_back(96);
    load_at(100, 16'h1111, 4'b0000);
    push_frame(16'h1111, 4'b0000);
    upd_q.push_back(128);
    load_at(128, 16'h3333, 4'b0000);
    push_frame(16'h3333, 4'b0000);
    upd_q.push_back(160);
    load_at(170, 16'h0050, 4'b0000);
    push_frame(16'h0050, 4'b0000);
    upd_q.push_back(192);
    for (int k = 0; k < 500 && cyc < 226; k++) @(negedge clk);
    mon_en = 1'b0;
    chk("end_reached", cyc >= 226, 1);
    chk("digits_left", exp_q.size(), 0);
    chk("updates_left", upd_q.size(), 0);
    chk("frame_done_count", fd_cnt, 7);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
